inst_mem_loader: RTL and testbench
==================================

// Module: inst_mem_loader
// PURPOSE
//  Write-side companion of the byte-wide instruction memory (4096 x 8, big endian).
//  - Accepts 32-bit instruction words over a valid/ready stream (boot/test program load).
//  - Writes each word as 4 consecutive bytes, MSB first, at increasing byte addresses.
//  - Stores word N at BASE_ADDR+4N, so the fetch side later reads {b[a],b[a+1],b[a+2],b[a+3]}.
// PARAMETERS
//  ADDR_W     12     byte-address width of the instruction memory
//  MEM_BYTES  4096   memory size in bytes; must equal 2**ADDR_W
//  BASE_ADDR  0      first byte address written; must be a multiple of 4 and < MEM_BYTES
// PORTS
//  clk         in   1         rising-edge clock
//  reset       in   1         asynchronous, active-low reset
//  start       in   1         1-cycle pulse: begin a load session (ignored unless IDLE)
//  in_valid    in   1         in_data/in_last valid
//  in_data     in   32        instruction word
//  in_last     in   1         marks the final word of the session
//  in_ready    out  1         loader can accept a word this cycle
//  mem_we      out  1         byte write enable to instruction memory
//  mem_addr    out  ADDR_W    byte address
//  mem_wdata   out  8         byte data
//  busy        out  1         session in progress (state != IDLE)
//  done        out  1         1-cycle pulse at session end
//  overflow    out  1         sticky: session ended because memory was full
//  word_count  out  ADDR_W-1  words written in the current/last session
// BEHAVIOUR
//  Reset (reset=0, async):
//  - State=IDLE; pointer=BASE_ADDR.
//  - All outputs 0, word_count=0; mem_we drops immediately, with no partial-word completion.
//  States:
//  - IDLE: in_ready=0.
//      start=1 -> pointer=BASE_ADDR, word_count=0, overflow=0; go WAIT.
//  - WAIT: in_ready=1.
//      in_valid&in_ready -> latch in_data, in_last; byte_idx=0; go WRITE.
//  - WRITE: in_ready=0; mem_we=1 for exactly 4 cycles, byte_idx 0..3.
//      mem_addr=pointer+byte_idx.
//      mem_wdata: byte 0=word[31:24], 1=[23:16], 2=[15:8], 3=[7:0].
//      After byte 3: pointer+=4, word_count+=1. Then:
//        - latched last=1 -> DONE;
//        - else pointer+4 > MEM_BYTES (next word would not fit) -> overflow=1, DONE;
//        - else -> WAIT.
//  - DONE: done=1 for one cycle, mem_we=0, in_ready=0; go IDLE.
//  Outputs and timing:
//  - All outputs are decoded from registers only; no combinational path from in_* to outputs.
//  - Handshake at cycle T -> writes in cycles T+1..T+4; DONE at T+5 or next in_ready at T+5.
//  - Peak rate: 1 word per 5 cycles.
//  Boundary rules:
//  - start while busy: ignored.
//  - in_valid in IDLE/WRITE/DONE: not accepted, no side effect; sender must hold data.
//  - pointer never wraps: overflow terminates the session before address ADDR_W rolls over.
//  - overflow and word_count hold after DONE until the next accepted start.
//  - The word that would overflow is never accepted (in_ready stays 0).
//  - in_last on a word that exactly fills memory -> done, overflow=0.
// TESTING
//  - start; words 0xDEADBEEF, 0x00112233 (last).
//      -> bytes DE AD BE EF 00 11 22 33 at addr 0..7; done 1 cycle; word_count=2; overflow=0.
//  - in_valid held high continuously, 3 words.
//      -> in_ready high only in WAIT; exactly 3 handshakes, 5 cycles apart; 12 mem_we pulses.
//  - BASE_ADDR=4088; 3 words, none with last.
//      -> 2 words written at 4088..4095; overflow=1; done; 3rd word never handshaken.
//  - Assert reset during byte 1 of 0xCAFEF00D.
//      -> mem_we=0 at once, all outputs 0.
//      -> new start + 0x01020304 (last) writes 01 02 03 04 at BASE_ADDR.
//  - Pulse start while in WRITE; in_valid high while IDLE.
//      -> no restart, counters unchanged; no handshake while IDLE.

Source files
------------

// File: rtl/inst_mem_loader.sv
// Purpose: load 32-bit instruction words into a byte-wide big-endian memory, MSB byte first.
// Latency: a word accepted at cycle T is written over T+1..T+4; next accept or done at T+5.
// Backpressure: in_ready is high only while waiting for a word; one word per 5 cycles at best.
module inst_mem_loader #(
  parameter int ADDR_W    = 12,
  parameter int MEM_BYTES = 4096,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  input  logic [31:0]       in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-2:0] word_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_WRITE, S_DONE} state_t;

  // One extra pointer bit so the address just past the end of memory is representable
  // and the fit check never sees a wrapped value.
  localparam logic [ADDR_W:0] BASE_P = (ADDR_W+1)'(BASE_ADDR);
  localparam logic [ADDR_W:0] LIMIT  = (ADDR_W+1)'(MEM_BYTES);
  localparam logic [ADDR_W:0] STEP   = (ADDR_W+1)'(4);

  state_t          state;
  state_t          state_nxt;
  logic [ADDR_W:0] ptr;
  logic [ADDR_W:0] ptr_inc;
  logic [1:0]      byte_idx;
  logic [31:0]     word_r;
  logic            last_r;
  logic            next_no_fit;
  logic            start_ok;
  logic            accept;
  logic            word_end;

  assign ptr_inc     = ptr + STEP;
  assign next_no_fit = (ptr_inc + STEP) > LIMIT;
  assign start_ok    = (state == S_IDLE) && start;
  assign accept      = (state == S_WAIT) && in_valid;
  assign word_end    = (state == S_WRITE) && (byte_idx == 2'd3);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived outputs; byte address/data are zero when not writing.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != S_IDLE);
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = S_WRITE;
      end
      S_WRITE: begin
        mem_we   = 1'b1;
        mem_addr = ptr[ADDR_W-1:0] + ADDR_W'(byte_idx);
        unique case (byte_idx)
          2'd0: mem_wdata = word_r[31:24];
          2'd1: mem_wdata = word_r[23:16];
          2'd2: mem_wdata = word_r[15:8];
          2'd3: mem_wdata = word_r[7:0];
        endcase
        if (byte_idx == 2'd3) begin
          if (last_r || next_no_fit) state_nxt = S_DONE;
          else                       state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: session pointer, word latch, byte counter, sticky overflow and word count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr        <= BASE_P;
      byte_idx   <= 2'd0;
      word_r     <= '0;
      last_r     <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      if (start_ok) begin
        ptr        <= BASE_P;
        word_count <= '0;
        overflow   <= 1'b0;
      end
      if (accept) begin
        word_r   <= in_data;
        last_r   <= in_last;
        byte_idx <= 2'd0;
      end
      if (state == S_WRITE) begin
        byte_idx <= byte_idx + 2'd1;
      end
      if (word_end) begin
        ptr        <= ptr_inc;
        word_count <= word_count + (ADDR_W-1)'(1);
        // A last word that exactly fills memory ends cleanly, not as an overflow.
        if (!last_r && next_no_fit) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, start1;
  logic        in_valid, in_last;
  logic [31:0] in_data;

  logic        in_ready0, mem_we0, busy0, done0, overflow0;
  logic [11:0] mem_addr0;
  logic [7:0]  mem_wdata0;
  logic [10:0] word_count0;
  logic        in_ready1, mem_we1, busy1, done1, overflow1;
  logic [11:0] mem_addr1;
  logic [7:0]  mem_wdata1;
  logic [10:0] word_count1;

  always #5 clk = ~clk;

  inst_mem_loader #(.ADDR_W(12), .MEM_BYTES(4096), .BASE_ADDR(0)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_wdata(mem_wdata0), .busy(busy0), .done(done0), .overflow(overflow0),
    .word_count(word_count0)
  );

  inst_mem_loader #(.ADDR_W(12), .MEM_BYTES(4096), .BASE_ADDR(4088)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .busy(busy1), .done(done1), .overflow(overflow1),
    .word_count(word_count1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Expected byte writes {addr, data} and expected done status {overflow, word_count}.
  logic [19:0] wq0[$], wq1[$];
  logic [11:0] dq0[$], dq1[$];
  int hs0 = 0, hs1 = 0, we0 = 0, we1 = 0;
  int hs_cyc0[$];
  logic dprev0 = 1'b0, dprev1 = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard whenever either loader writes a byte or signals done.
  always @(negedge clk) begin
    logic [19:0] e;
    logic [11:0] d;
    if (!reset) begin
      dprev0 = 1'b0;
      dprev1 = 1'b0;
    end else begin
      if (mem_we0) begin
        we0++;
        if (wq0.size() == 0) flag("wr0_unexpected");
        else begin
          e = wq0.pop_front();
          chk("wr0_addr", mem_addr0, e[19:8]);
          chk("wr0_data", mem_wdata0, e[7:0]);
        end
      end
      if (mem_we1) begin
        we1++;
        if (wq1.size() == 0) flag("wr1_unexpected");
        else begin
          e = wq1.pop_front();
          chk("wr1_addr", mem_addr1, e[19:8]);
          chk("wr1_data", mem_wdata1, e[7:0]);
        end
      end
      if (done0) begin
        chk("done0_pulse_width", dprev0, 0);
        if (dq0.size() == 0) flag("done0_unexpected");
        else begin
          d = dq0.pop_front();
          chk("done0_word_count", word_count0, d[10:0]);
          chk("done0_overflow", overflow0, d[11]);
        end
      end
      if (done1) begin
        chk("done1_pulse_width", dprev1, 0);
        if (dq1.size() == 0) flag("done1_unexpected");
        else begin
          d = dq1.pop_front();
          chk("done1_word_count", word_count1, d[10:0]);
          chk("done1_overflow", overflow1, d[11]);
        end
      end
      if (in_ready0) begin
        chk("rdy0_while_writing", mem_we0, 0);
        chk("rdy0_busy", busy0, 1);
      end
      if (in_ready1) chk("rdy1_while_writing", mem_we1, 0);
      if (in_valid && in_ready0) begin
        hs0++;
        hs_cyc0.push_back(cyc);
      end
      if (in_valid && in_ready1) hs1++;
      dprev0 = done0;
      dprev1 = done1;
    end
  end

  task automatic exp_word(input int sel, input logic [11:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [11:0] ai;
      logic [7:0]  b;
      ai = a + 12'(i);
      b  = w[31 - 8*i -: 8];
      if (sel == 0) wq0.push_back({ai, b});
      else          wq1.push_back({ai, b});
    end
  endtask

  task automatic exp_done(input int sel, input logic [10:0] wc, input logic ovf);
    if (sel == 0) dq0.push_back({ovf, wc});
    else          dq1.push_back({ovf, wc});
  endtask

  task automatic pulse_start(input int sel);
    @(posedge clk); #1;
    if (sel == 0) start0 = 1'b1;
    else          start1 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  // Present a word and hold it until the selected loader handshakes (bounded).
  task automatic send(input int sel, input logic [31:0] w, input logic last, input bit keep);
    in_data  = w;
    in_last  = last;
    in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if ((sel == 0) ? in_ready0 : in_ready1) begin
        @(posedge clk); #1;
        if (!keep) in_valid = 1'b0;
        return;
      end
    end
    flag("handshake_timeout");
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int sel, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((sel == 0) ? done0 : done1) return;
    end
    flag("done_timeout");
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready0"},   in_ready0, 0);
    chk({tag, "_mem_we0"},     mem_we0, 0);
    chk({tag, "_mem_addr0"},   mem_addr0, 0);
    chk({tag, "_mem_wdata0"},  mem_wdata0, 0);
    chk({tag, "_busy0"},       busy0, 0);
    chk({tag, "_done0"},       done0, 0);
    chk({tag, "_overflow0"},   overflow0, 0);
    chk({tag, "_word_count0"}, word_count0, 0);
    chk({tag, "_mem_we1"},     mem_we1, 0);
    chk({tag, "_mem_addr1"},   mem_addr1, 0);
    chk({tag, "_busy1"},       busy1, 0);
    chk({tag, "_overflow1"},   overflow1, 0);
  endtask

  initial begin
    int h, w;
    bit seen;
    reset    = 1'b0;
    start0   = 1'b0;
    start1   = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    reset = 1'b1;

    // in_valid while both loaders are idle: no handshake, no write.
    in_data  = 32'h5555_AAAA;
    in_valid = 1'b1;
    repeat (6) @(negedge clk);
    in_valid = 1'b0;
    chk("idle_no_handshake0", hs0, 0);
    chk("idle_no_handshake1", hs1, 0);

    // Two-word session, big-endian byte order.
    pulse_start(0);
    exp_word(0, 12'd0, 32'hDEAD_BEEF);
    exp_word(0, 12'd4, 32'h0011_2233);
    exp_done(0, 11'd2, 1'b0);
    send(0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    send(0, 32'h0011_2233, 1'b1, 1'b0);
    wait_done(0, 20);
    repeat (3) @(negedge clk);
    chk("t1_wc_hold", word_count0, 2);
    chk("t1_busy_after", busy0, 0);

    // in_valid held high across three words: handshakes only in WAIT, 5 cycles apart.
    pulse_start(0);
    h = hs0;
    w = we0;
    hs_cyc0.delete();
    exp_word(0, 12'd0, 32'h1122_3344);
    exp_word(0, 12'd4, 32'h5566_7788);
    exp_word(0, 12'd8, 32'h99AA_BBCC);
    exp_done(0, 11'd3, 1'b0);
    send(0, 32'h1122_3344, 1'b0, 1'b1);
    send(0, 32'h5566_7788, 1'b0, 1'b1);
    send(0, 32'h99AA_BBCC, 1'b1, 1'b0);
    wait_done(0, 20);
    chk("t2_handshakes", hs0 - h, 3);
    chk("t2_we_pulses", we0 - w, 12);
    if (hs_cyc0.size() == 3) begin
      chk("t2_gap_1", hs_cyc0[1] - hs_cyc0[0], 5);
      chk("t2_gap_2", hs_cyc0[2] - hs_cyc0[1], 5);
    end else flag("t2_handshake_log");

    // start pulsed mid-write is ignored: pointer and count keep going.
    pulse_start(0);
    exp_word(0, 12'd0, 32'hAABB_CCDD);
    send(0, 32'hAABB_CCDD, 1'b0, 1'b0);
    pulse_start(0);
    exp_word(0, 12'd4, 32'h1234_5678);
    exp_done(0, 11'd2, 1'b0);
    send(0, 32'h1234_5678, 1'b1, 1'b0);
    wait_done(0, 20);

    // Overflow near the top of memory; the third word is never accepted.
    h = hs0;
    pulse_start(1);
    w = hs1;
    exp_word(1, 12'd4088, 32'hA1A2_A3A4);
    exp_word(1, 12'd4092, 32'hB1B2_B3B4);
    exp_done(1, 11'd2, 1'b1);
    send(1, 32'hA1A2_A3A4, 1'b0, 1'b0);
    send(1, 32'hB1B2_B3B4, 1'b0, 1'b0);
    in_data  = 32'hC1C2_C3C4;
    in_valid = 1'b1;
    wait_done(1, 30);
    repeat (10) @(negedge clk);
    in_valid = 1'b0;
    chk("t3_handshakes", hs1 - w, 2);
    chk("t3_overflow_sticky", overflow1, 1);
    chk("t3_wc_sticky", word_count1, 2);
    chk("t3_other_idle", hs0 - h, 0);

    // Reset asserted during byte 1 of a word.
    pulse_start(0);
    exp_word(0, 12'd0, 32'hCAFE_F00D);
    send(0, 32'hCAFE_F00D, 1'b0, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_we0 && mem_addr0 == 12'd1) seen = 1'b1;
    end
    if (!seen) flag("t4_byte1_not_seen");
    #2 reset = 1'b0;
    #1 chk_all_zero("t4_midreset");
    wq0.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    pulse_start(0);
    exp_word(0, 12'd0, 32'h0102_0304);
    exp_done(0, 11'd1, 1'b0);
    send(0, 32'h0102_0304, 1'b1, 1'b0);
    wait_done(0, 20);

    // Last word exactly fills memory: done without overflow.
    pulse_start(1);
    exp_word(1, 12'd4088, 32'h0BAD_CAFE);
    exp_word(1, 12'd4092, 32'hFEED_FACE);
    exp_done(1, 11'd2, 1'b0);
    send(1, 32'h0BAD_CAFE, 1'b0, 1'b0);
    send(1, 32'hFEED_FACE, 1'b1, 1'b0);
    wait_done(1, 20);
    repeat (2) @(negedge clk);
    chk("t6_overflow", overflow1, 0);

    repeat (3) @(negedge clk);
    chk("end_wq0_empty", wq0.size(), 0);
    chk("end_wq1_empty", wq1.size(), 0);
    chk("end_dq0_empty", dq0.size(), 0);
    chk("end_dq1_empty", dq1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
